scarv_cop_palu_ctrl: RTL and testbench

//  Sequencer for the combinational packed ALU. Accepts one decoded instruction per handshake,

---
 rtl/scarv_cop_palu_ctrl_pkg.sv | 22 ++
 rtl/scarv_cop_palu_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_scarv_cop_palu_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_palu_ctrl_pkg.sv
// Shared encodings for the packed-ALU sequencer: FSM states and the
// instruction class/subclass/pack-width codes seen on the decode interface.
package scarv_cop_palu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } palu_state_e;

  localparam logic [2:0] CLASS_MOVE         = 3'b001;
  localparam logic [2:0] CLASS_PACKED_ARITH = 3'b010;

  localparam logic [3:0] SUBCL_ADD    = 4'b0001;
  localparam logic [3:0] SUBCL_MV2COP = 4'b0011;
  localparam logic [3:0] SUBCL_CMOV   = 4'b0101;

  localparam logic [2:0] PW_32 = 3'b000;
  localparam logic [2:0] PW_16 = 3'b001;
  localparam logic [2:0] PW_8  = 3'b010;

endpackage

// File: rtl/scarv_cop_palu_ctrl.sv
// Sequencer around the combinational packed ALU: accepts one decoded
// instruction, holds its operands for the PALU, then requests the CPR write port.
module scarv_cop_palu_ctrl
  import scarv_cop_palu_ctrl_pkg::*;
#(
  parameter int EXEC_TIMEOUT = 8,
  parameter int CNT_W        = 32
) (
  input  logic             g_clk,
  input  logic             g_reset,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [2:0]       id_class,
  input  logic [3:0]       id_subclass,
  input  logic [2:0]       id_pw,
  input  logic [31:0]      id_imm,
  input  logic [3:0]       id_crs1,
  input  logic [3:0]       id_crs2,
  input  logic [3:0]       id_crd,
  input  logic [31:0]      id_gpr_rs1,
  output logic [3:0]       cpr_rs1_addr,
  output logic [3:0]       cpr_rs2_addr,
  output logic [3:0]       cpr_rs3_addr,
  input  logic [31:0]      cpr_rs1_rdata,
  input  logic [31:0]      cpr_rs2_rdata,
  input  logic [31:0]      cpr_rs3_rdata,
  output logic             palu_ivalid,
  input  logic             palu_idone,
  output logic [31:0]      palu_rs1,
  output logic [31:0]      palu_rs2,
  output logic [31:0]      palu_rs3,
  output logic [31:0]      palu_gpr_rs1,
  output logic [31:0]      palu_imm,
  output logic [2:0]       palu_pw,
  output logic [2:0]       palu_class,
  output logic [3:0]       palu_subclass,
  input  logic [3:0]       palu_ben,
  input  logic [31:0]      palu_wdata,
  output logic             wb_req,
  input  logic             wb_gnt,
  output logic [3:0]       wb_addr,
  output logic [3:0]       wb_ben,
  output logic [31:0]      wb_wdata,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] insn_count
);

  // Timer only needs to reach EXEC_TIMEOUT-1.
  localparam int TMR_W = (EXEC_TIMEOUT > 1) ? $clog2(EXEC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(EXEC_TIMEOUT - 1);

  palu_state_e      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [31:0]      gpr_q, gpr_d, imm_q, imm_d;
  logic [2:0]       pw_q, pw_d, cls_q, cls_d;
  logic [3:0]       sub_q, sub_d, crd_q, crd_d;
  logic [3:0]       ben_q, ben_d;
  logic [31:0]      wdata_q, wdata_d;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      gpr_q   <= '0;
      imm_q   <= '0;
      pw_q    <= '0;
      cls_q   <= '0;
      sub_q   <= '0;
      crd_q   <= '0;
      ben_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
      count_q <= count_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
      gpr_q   <= gpr_d;
      imm_q   <= imm_d;
      pw_q    <= pw_d;
      cls_q   <= cls_d;
      sub_q   <= sub_d;
      crd_q   <= crd_d;
      ben_q   <= ben_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fault_d = 1'b0;
    count_d = count_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    gpr_d   = gpr_q;
    imm_d   = imm_q;
    pw_d    = pw_q;
    cls_d   = cls_q;
    sub_d   = sub_q;
    crd_d   = crd_q;
    ben_d   = ben_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (id_valid) begin
          rs1_d   = cpr_rs1_rdata;
          rs2_d   = cpr_rs2_rdata;
          rs3_d   = cpr_rs3_rdata;
          gpr_d   = id_gpr_rs1;
          imm_d   = id_imm;
          pw_d    = id_pw;
          cls_d   = id_class;
          sub_d   = id_subclass;
          crd_d   = id_crd;
          timer_d = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (palu_idone) begin
          ben_d   = palu_ben;
          wdata_d = palu_wdata;
          // A zero byte-enable (failed CMOV) retires without touching the CPRs.
          if (palu_ben != 4'h0) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_IDLE;
            count_d = count_q + CNT_W'(1);
          end
        end else if (timer_q == TMR_LAST) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_WB: begin
        if (wb_gnt) begin
          state_d = ST_IDLE;
          count_d = count_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign id_ready      = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign palu_ivalid   = (state_q == ST_EXEC);
  assign wb_req        = (state_q == ST_WB);
  assign fault         = fault_q;
  assign insn_count    = count_q;

  // Read addresses bypass the pipeline so data arrives in the accept cycle.
  assign cpr_rs1_addr  = id_crs1;
  assign cpr_rs2_addr  = id_crs2;
  assign cpr_rs3_addr  = id_crd;

  assign palu_rs1      = rs1_q;
  assign palu_rs2      = rs2_q;
  assign palu_rs3      = rs3_q;
  assign palu_gpr_rs1  = gpr_q;
  assign palu_imm      = imm_q;
  assign palu_pw       = pw_q;
  assign palu_class    = cls_q;
  assign palu_subclass = sub_q;

  assign wb_addr       = crd_q;
  assign wb_ben        = ben_q;
  assign wb_wdata      = wdata_q;

endmodule

// File: tb/tb_scarv_cop_palu_ctrl.sv
// Scoreboard bench for the PALU sequencer: bench supplies the CPR file and a
// combinational PALU, and compares each granted writeback with predictions.
module tb_scarv_cop_palu_ctrl;
  import scarv_cop_palu_ctrl_pkg::*;

  logic        g_clk = 1'b0;
  logic        g_reset = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [2:0]  id_class = '0;
  logic [3:0]  id_subclass = '0;
  logic [2:0]  id_pw = '0;
  logic [31:0] id_imm = '0;
  logic [3:0]  id_crs1 = '0, id_crs2 = '0, id_crd = '0;
  logic [31:0] id_gpr_rs1 = '0;
  logic [3:0]  cpr_rs1_addr, cpr_rs2_addr, cpr_rs3_addr;
  logic [31:0] cpr_rs1_rdata, cpr_rs2_rdata, cpr_rs3_rdata;
  logic        palu_ivalid, palu_idone;
  logic [31:0] palu_rs1, palu_rs2, palu_rs3, palu_gpr_rs1, palu_imm;
  logic [2:0]  palu_pw, palu_class;
  logic [3:0]  palu_subclass, palu_ben;
  logic [31:0] palu_wdata;
  logic        wb_req;
  logic        wb_gnt = 1'b1;
  logic [3:0]  wb_addr, wb_ben;
  logic [31:0] wb_wdata;
  logic        busy, fault;
  logic [3:0]  insn_count;

  logic        palu_stall = 1'b0;
  logic [31:0] cpr [16];

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
  } wb_exp_t;
  wb_exp_t sb[$];

  int   tests_run = 0;
  int   tests_failed = 0;
  time  accept_time = 0;
  logic [3:0] exp_cnt = '0;

  scarv_cop_palu_ctrl #(.EXEC_TIMEOUT(8), .CNT_W(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_class(id_class),
    .id_subclass(id_subclass), .id_pw(id_pw), .id_imm(id_imm),
    .id_crs1(id_crs1), .id_crs2(id_crs2), .id_crd(id_crd), .id_gpr_rs1(id_gpr_rs1),
    .cpr_rs1_addr(cpr_rs1_addr), .cpr_rs2_addr(cpr_rs2_addr), .cpr_rs3_addr(cpr_rs3_addr),
    .cpr_rs1_rdata(cpr_rs1_rdata), .cpr_rs2_rdata(cpr_rs2_rdata), .cpr_rs3_rdata(cpr_rs3_rdata),
    .palu_ivalid(palu_ivalid), .palu_idone(palu_idone),
    .palu_rs1(palu_rs1), .palu_rs2(palu_rs2), .palu_rs3(palu_rs3),
    .palu_gpr_rs1(palu_gpr_rs1), .palu_imm(palu_imm), .palu_pw(palu_pw),
    .palu_class(palu_class), .palu_subclass(palu_subclass),
    .palu_ben(palu_ben), .palu_wdata(palu_wdata),
    .wb_req(wb_req), .wb_gnt(wb_gnt), .wb_addr(wb_addr), .wb_ben(wb_ben),
    .wb_wdata(wb_wdata), .busy(busy), .fault(fault), .insn_count(insn_count)
  );

  always #5 g_clk = ~g_clk;

  // Reference PALU behaviour: returns {ben, wdata}.
  function automatic logic [35:0] palu_fn(input logic [2:0] cls, input logic [3:0] sub,
                                          input logic [2:0] pw, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] g, input logic [31:0] imm);
    logic [31:0] r;
    logic [15:0] hi, lo;
    logic [3:0]  be;
    r  = '0;
    be = 4'hF;
    if (cls == CLASS_PACKED_ARITH && sub == SUBCL_ADD) begin
      hi = a[31:16] + b[31:16];
      lo = a[15:0] + b[15:0];
      r  = (pw == PW_16) ? {hi, lo} : a + b;
    end else if (cls == CLASS_MOVE && sub == SUBCL_MV2COP) begin
      r = g;
    end else if (cls == CLASS_MOVE && sub == SUBCL_CMOV) begin
      r  = a;
      be = (b == 32'h0) ? 4'hF : 4'h0;
    end else begin
      r = c ^ imm;
    end
    return {be, r};
  endfunction

  assign cpr_rs1_rdata = cpr[cpr_rs1_addr];
  assign cpr_rs2_rdata = cpr[cpr_rs2_addr];
  assign cpr_rs3_rdata = cpr[cpr_rs3_addr];
  assign palu_idone = palu_ivalid && !palu_stall;
  assign {palu_ben, palu_wdata} = palu_fn(palu_class, palu_subclass, palu_pw, palu_rs1,
                                          palu_rs2, palu_rs3, palu_gpr_rs1, palu_imm);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop on every granted writeback.
  always @(negedge g_clk) begin : wb_monitor
    wb_exp_t e;
    if (!g_reset && wb_req && wb_gnt) begin
      $display("[TB] wb addr=%0d ben=%h data=%h count=%0d", wb_addr, wb_ben, wb_wdata, insn_count);
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("wb_addr", 64'(wb_addr), 64'(e.addr));
        check("wb_ben", 64'(wb_ben), 64'(e.ben));
        check("wb_wdata", 64'(wb_wdata), 64'(e.wdata));
      end
    end
  end

  task automatic issue(input logic [2:0] cls, input logic [3:0] sub, input logic [2:0] pw,
                       input logic [31:0] imm, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [31:0] gpr, input bit exp_wb);
    int      waited;
    logic [35:0] res;
    wb_exp_t e;
    waited = 0;
    while (!id_ready && waited < 50) begin
      @(posedge g_clk); #1;
      waited++;
    end
    if (waited >= 50) check("issue_ready_timeout", 64'd0, 64'd1);
    id_class = cls; id_subclass = sub; id_pw = pw; id_imm = imm;
    id_crs1 = rs1; id_crs2 = rs2; id_crd = rd; id_gpr_rs1 = gpr;
    id_valid = 1'b1;
    res = palu_fn(cls, sub, pw, cpr[rs1], cpr[rs2], cpr[rd], gpr, imm);
    @(posedge g_clk);
    accept_time = $time;
    #1 id_valid = 1'b0;
    $display("[TB] issue class=%0d sub=%0d crd=%0d ben=%h data=%h", cls, sub, rd, res[35:32], res[31:0]);
    if (exp_wb && res[35:32] != 4'h0) begin
      e.addr = rd; e.ben = res[35:32]; e.wdata = res[31:0];
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n >= 50) check("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_id_ready"}, 64'(id_ready), 64'd1);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_ivalid"}, 64'(palu_ivalid), 64'd0);
    check({pfx, "_wb_req"}, 64'(wb_req), 64'd0);
    check({pfx, "_fault"}, 64'(fault), 64'd0);
    check({pfx, "_count"}, 64'(insn_count), 64'd0);
    check({pfx, "_gpr"}, 64'(palu_gpr_rs1), 64'd0);
    check({pfx, "_rs1"}, 64'(palu_rs1), 64'd0);
    check({pfx, "_wdata"}, 64'(wb_wdata), 64'd0);
    check({pfx, "_wb_addr"}, 64'(wb_addr), 64'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    time prev_t;
    for (int i = 0; i < 16; i++) cpr[i] = 32'h1111_0000 * i + 32'h0000_0101 * i;
    cpr[1] = 32'h0001_FFFF;
    cpr[2] = 32'h0001_0001;
    cpr[5] = 32'hAAAA_5555;
    cpr[6] = 32'h0000_0001;
    cpr[4] = 32'h1234_5678;

    repeat (2) @(posedge g_clk);
    @(negedge g_clk);
    check_reset_outputs("reset");
    @(posedge g_clk); #1 g_reset = 1'b0;

    // ADD.PX pw=16 with grant tied high.
    issue(CLASS_PACKED_ARITH, SUBCL_ADD, PW_16, 32'h0, 4'd1, 4'd2, 4'd3, 32'h0, 1'b1);
    exp_cnt++;
    @(negedge g_clk);
    check("add_exec_ivalid", 64'(palu_ivalid), 64'd1);
    check("add_exec_ready", 64'(id_ready), 64'd0);
    check("add_exec_rs1", 64'(palu_rs1), 64'h0001_FFFF);
    check("add_exec_wbreq", 64'(wb_req), 64'd0);
    @(negedge g_clk);
    check("add_wb_req", 64'(wb_req), 64'd1);
    check("add_wb_ivalid", 64'(palu_ivalid), 64'd0);
    check("add_wb_ready", 64'(id_ready), 64'd0);
    @(negedge g_clk);
    check("add_idle_ready", 64'(id_ready), 64'd1);
    check("add_count", 64'(insn_count), 64'(exp_cnt));
    @(posedge g_clk); #1;

    // Failed CMOV: zero byte enables, retires with no write.
    issue(CLASS_MOVE, SUBCL_CMOV, PW_32, 32'h0, 4'd5, 4'd6, 4'd7, 32'h0, 1'b1);
    exp_cnt++;
    @(negedge g_clk);
    check("cmov_exec_ivalid", 64'(palu_ivalid), 64'd1);
    @(negedge g_clk);
    check("cmov_idle_ready", 64'(id_ready), 64'd1);
    check("cmov_no_wbreq", 64'(wb_req), 64'd0);
    check("cmov_count", 64'(insn_count), 64'(exp_cnt));
    @(posedge g_clk); #1;

    // Uses the third read port and the immediate.
    issue(3'b111, 4'd0, PW_32, 32'h0F0F_0000, 4'd0, 4'd0, 4'd4, 32'h0, 1'b1);
    exp_cnt++;
    wait_idle();
    check("xor_count", 64'(insn_count), 64'(exp_cnt));

    // Grant withheld for 5 WB cycles; a decode pulse meanwhile must be dropped.
    wb_gnt = 1'b0;
    issue(CLASS_MOVE, SUBCL_MV2COP, PW_32, 32'h0, 4'd0, 4'd0, 4'd5, 32'hDEAD_BEEF, 1'b1);
    exp_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge g_clk); #1;
      if (i == 2) begin
        id_class = CLASS_MOVE; id_subclass = SUBCL_MV2COP; id_crd = 4'd9;
        id_gpr_rs1 = 32'h5555_AAAA; id_valid = 1'b1;
      end else begin
        id_valid = 1'b0;
      end
      @(negedge g_clk);
      check("stall_wb_req", 64'(wb_req), 64'd1);
      check("stall_wb_addr", 64'(wb_addr), 64'd5);
      check("stall_wb_ben", 64'(wb_ben), 64'hF);
      check("stall_wb_wdata", 64'(wb_wdata), 64'hDEAD_BEEF);
    end
    @(posedge g_clk); #1;
    id_valid = 1'b0;
    wb_gnt = 1'b1;
    @(posedge g_clk); #1;
    check("stall_retire_count", 64'(insn_count), 64'(exp_cnt));
    check("stall_retire_busy", 64'(busy), 64'd0);
    @(posedge g_clk); #1;
    check("ignored_pulse_busy", 64'(busy), 64'd0);

    // EXEC timeout: no idone for 8 cycles.
    palu_stall = 1'b1;
    issue(CLASS_PACKED_ARITH, SUBCL_ADD, PW_32, 32'h0, 4'd1, 4'd2, 4'd8, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge g_clk);
      check("to_exec_busy", 64'(busy), 64'd1);
      check("to_exec_fault", 64'(fault), 64'd0);
      check("to_exec_wbreq", 64'(wb_req), 64'd0);
    end
    @(negedge g_clk);
    check("to_fault_pulse", 64'(fault), 64'd1);
    check("to_ready", 64'(id_ready), 64'd1);
    check("to_count", 64'(insn_count), 64'(exp_cnt));
    @(negedge g_clk);
    check("to_fault_clear", 64'(fault), 64'd0);
    palu_stall = 1'b0;
    @(posedge g_clk); #1;

    // Reset while in EXEC.
    palu_stall = 1'b1;
    issue(CLASS_MOVE, SUBCL_MV2COP, PW_32, 32'h0, 4'd0, 4'd0, 4'd2, 32'hCAFE_F00D, 1'b0);
    @(negedge g_clk);
    check("rst_exec_pre_busy", 64'(busy), 64'd1);
    g_reset = 1'b1;
    @(negedge g_clk);
    check_reset_outputs("rst_exec");
    palu_stall = 1'b0;
    @(posedge g_clk); #1 g_reset = 1'b0;

    // Reset while in WB.
    wb_gnt = 1'b0;
    issue(CLASS_MOVE, SUBCL_MV2COP, PW_32, 32'h0, 4'd0, 4'd0, 4'd6, 32'h1234_5678, 1'b0);
    @(posedge g_clk); #1;
    @(negedge g_clk);
    check("rst_wb_pre_req", 64'(wb_req), 64'd1);
    g_reset = 1'b1;
    @(negedge g_clk);
    check_reset_outputs("rst_wb");
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    wb_gnt = 1'b1;
    exp_cnt = '0;

    // 16 back-to-back MV2COP: counter wraps and throughput is one per 3 cycles.
    prev_t = 0;
    for (int i = 0; i < 16; i++) begin
      issue(CLASS_MOVE, SUBCL_MV2COP, PW_32, 32'h0, 4'd0, 4'd0, 4'(i), 32'h100 + 32'(i), 1'b1);
      if (i > 0) check("b2b_spacing", 64'((accept_time - prev_t) / 10), 64'd3);
      prev_t = accept_time;
      exp_cnt++;
      repeat (2) begin @(posedge g_clk); #1; end
      check("b2b_count", 64'(insn_count), 64'(exp_cnt));
    end
    check("wrap_count", 64'(insn_count), 64'd0);

    repeat (3) @(posedge g_clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
